// File: rtl/echo_pkg.sv
// echo_pkg: types and default constants shared by the echo writer and the correlator.
// Latency: n/a, definitions only.
// Backpressure: n/a.
// Contents: capture state enum, sample/count widths, default timing constants, busy decode helper.
package echo_pkg;

  localparam int unsigned SAMPLE_W            = 12;
  localparam int unsigned SCNT_W              = 14;
  localparam int unsigned TX_HALF_PERIOD_DEF  = 278;
  localparam int unsigned TX_CYCLES_DEF       = 8;
  localparam int unsigned SAMPLE_DIV_DEF      = 50;
  localparam int unsigned CAPTURE_SAMPLES_DEF = 8192;
  localparam int unsigned DEADTIME_DEF        = 4;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    TX_CAPTURE = 2'd1,
    CAPTURE    = 2'd2,
    DONE       = 2'd3
  } cap_state_e;

  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef logic [SCNT_W-1:0]   scnt_t;

  function automatic logic is_busy(input cap_state_e s);
    return (s == TX_CAPTURE) || (s == CAPTURE);
  endfunction

endpackage

// File: rtl/echo_capture_writer_tx_burst_gen.sv
// tx_burst_gen: fixed-length two-phase transducer burst generator.
// Latency: start -> first phase on tx_p/tx_n next cycle; tx outputs registered; burst_done is a combinational strobe.
// Backpressure: none; start restarts from phase 0 at any time, stop ends the burst immediately.
// Ports: clk_50M, rst_n (async active-low); start, stop controls; tx_p/tx_n drive; burst_done high in the last burst cycle.
// Build option: ECHO_CAPTURE_DEADTIME_EN holds both outputs low for DEADTIME cycles at the start of every half-period.
module tx_burst_gen
  import echo_pkg::*;
#(
  parameter int unsigned TX_HALF_PERIOD = TX_HALF_PERIOD_DEF,
  parameter int unsigned TX_CYCLES      = TX_CYCLES_DEF,
  parameter int unsigned DEADTIME       = DEADTIME_DEF
) (
  input  logic clk_50M,
  input  logic rst_n,
  input  logic start,
  input  logic stop,
  output logic tx_p,
  output logic tx_n,
  output logic burst_done
);

  localparam int unsigned CW = (TX_HALF_PERIOD > 1) ? $clog2(TX_HALF_PERIOD) : 1;
  localparam int unsigned IW = $clog2(2 * TX_CYCLES);
  localparam logic [CW-1:0] HALF_LAST = CW'(TX_HALF_PERIOD - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(2 * TX_CYCLES - 1);
`ifdef ECHO_CAPTURE_DEADTIME_EN
  localparam bit DT_EN = 1'b1;
`else
  localparam bit DT_EN = 1'b0;
`endif

  logic          running_q, running_d;
  logic [CW-1:0] half_cnt_q, half_cnt_d;
  logic [IW-1:0] half_idx_q, half_idx_d;
  logic          tx_p_q, tx_p_d, tx_n_q, tx_n_d;
  logic          in_gap;

  always_comb begin
    running_d  = running_q;
    half_cnt_d = half_cnt_q;
    half_idx_d = half_idx_q;
    burst_done = running_q && (half_cnt_q == HALF_LAST) && (half_idx_q == IDX_LAST);
    if (start) begin
      running_d  = 1'b1;
      half_cnt_d = '0;
      half_idx_d = '0;
    end else if (stop) begin
      running_d = 1'b0;
    end else if (running_q) begin
      if (half_cnt_q == HALF_LAST) begin
        half_cnt_d = '0;
        if (half_idx_q == IDX_LAST) running_d = 1'b0;
        else                        half_idx_d = half_idx_q + 1'b1;
      end else begin
        half_cnt_d = half_cnt_q + 1'b1;
      end
    end
    // Dead time eats into the front of each half-period so the period itself never stretches.
    in_gap = DT_EN && (32'(half_cnt_d) < DEADTIME);
    // Even half-periods drive the positive phase, odd ones the negative phase.
    tx_p_d = running_d && !half_idx_d[0] && !in_gap;
    tx_n_d = running_d &&  half_idx_d[0] && !in_gap;
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      running_q  <= 1'b0;
      half_cnt_q <= '0;
      half_idx_q <= '0;
      tx_p_q     <= 1'b0;
      tx_n_q     <= 1'b0;
    end else begin
      running_q  <= running_d;
      half_cnt_q <= half_cnt_d;
      half_idx_q <= half_idx_d;
      tx_p_q     <= tx_p_d;
      tx_n_q     <= tx_n_d;
    end
  end

  assign tx_p = tx_p_q;
  assign tx_n = tx_n_q;

endmodule

// File: rtl/echo_capture_writer.sv
// echo_capture_writer: start-triggered transmit burst, ADC conversion pacing and sample-FIFO writer.
// Latency: all outputs registered; start -> tx_p and adc_conv_start +1 cycle; adc_valid -> fifo_wrreq +1 cycle.
// Backpressure: none; a sample arriving while fifo_full is dropped but still counted, and overflow_flag sticks.
// Ports: clk_50M, rst_n (async active-low); sys_start_pulse starts/restarts a measurement;
//   adc_conv_start, adc_valid, adc_data ADC side; fifo_wrreq, fifo_data, fifo_full sample FIFO write side;
//   tx_p, tx_n transducer drive; busy, capture_done, overflow_flag, sample_cnt status.
// Build option: ECHO_CAPTURE_DEADTIME_EN enables DEADTIME both-low gaps at each tx phase change.
module echo_capture_writer
  import echo_pkg::*;
#(
  parameter int unsigned TX_HALF_PERIOD  = TX_HALF_PERIOD_DEF,
  parameter int unsigned TX_CYCLES       = TX_CYCLES_DEF,
  parameter int unsigned SAMPLE_DIV      = SAMPLE_DIV_DEF,
  parameter int unsigned CAPTURE_SAMPLES = CAPTURE_SAMPLES_DEF,
  parameter int unsigned DEADTIME        = DEADTIME_DEF
) (
  input  logic                clk_50M,
  input  logic                rst_n,
  input  logic                sys_start_pulse,
  output logic                adc_conv_start,
  input  logic                adc_valid,
  input  logic [SAMPLE_W-1:0] adc_data,
  output logic                fifo_wrreq,
  output logic [SAMPLE_W-1:0] fifo_data,
  input  logic                fifo_full,
  output logic                tx_p,
  output logic                tx_n,
  output logic                busy,
  output logic                capture_done,
  output logic                overflow_flag,
  output logic [SCNT_W-1:0]   sample_cnt
);

  localparam scnt_t CAP_N = SCNT_W'(CAPTURE_SAMPLES);
  localparam int unsigned DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);

  cap_state_e    state_q, state_d;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  scnt_t         req_cnt_q, req_cnt_d;
  scnt_t         sample_cnt_q, sample_cnt_d;
  sample_t       data_q, data_d;
  logic          conv_q, conv_d, wr_q, wr_d, done_q, done_d;
  logic          ovf_q, ovf_d, busy_q, busy_d;
  logic          accept, done_fire, burst_done;

  // A sample coinciding with a restart belongs to neither run and is discarded.
  assign accept    = adc_valid && is_busy(state_q) && !sys_start_pulse;
  assign done_fire = accept && (sample_cnt_q == CAP_N - 1'b1);

  tx_burst_gen #(
    .TX_HALF_PERIOD (TX_HALF_PERIOD),
    .TX_CYCLES      (TX_CYCLES),
    .DEADTIME       (DEADTIME)
  ) u_tx (
    .clk_50M    (clk_50M),
    .rst_n      (rst_n),
    .start      (sys_start_pulse),
    .stop       (done_fire),
    .tx_p       (tx_p),
    .tx_n       (tx_n),
    .burst_done (burst_done)
  );

  // Start (or restart) beats everything; completion beats end-of-burst.
  always_comb begin
    state_d = state_q;
    if (sys_start_pulse)                          state_d = TX_CAPTURE;
    else if (done_fire)                           state_d = DONE;
    else if (state_q == TX_CAPTURE && burst_done) state_d = CAPTURE;
  end

  always_comb begin
    div_cnt_d    = div_cnt_q;
    req_cnt_d    = req_cnt_q;
    sample_cnt_d = sample_cnt_q;
    data_d       = data_q;
    ovf_d        = ovf_q;
    conv_d       = 1'b0;
    wr_d         = 1'b0;
    if (sys_start_pulse) begin
      // First request lands in the same cycle as the first tx edge, so FIFO index 0 is time zero.
      conv_d       = 1'b1;
      div_cnt_d    = '0;
      req_cnt_d    = SCNT_W'(1);
      sample_cnt_d = '0;
      ovf_d        = 1'b0;
    end else begin
      if (is_busy(state_q) && !done_fire) begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          if (req_cnt_q != CAP_N) begin
            conv_d    = 1'b1;
            req_cnt_d = req_cnt_q + 1'b1;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      if (accept) begin
        // Dropped samples still advance the count to keep FIFO index aligned with time.
        sample_cnt_d = sample_cnt_q + 1'b1;
        if (fifo_full) begin
          ovf_d = 1'b1;
        end else begin
          wr_d   = 1'b1;
          data_d = adc_data;
        end
      end
    end
    done_d = done_fire;
    busy_d = is_busy(state_d);
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      div_cnt_q    <= '0;
      req_cnt_q    <= '0;
      sample_cnt_q <= '0;
      data_q       <= '0;
      conv_q       <= 1'b0;
      wr_q         <= 1'b0;
      done_q       <= 1'b0;
      ovf_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      req_cnt_q    <= req_cnt_d;
      sample_cnt_q <= sample_cnt_d;
      data_q       <= data_d;
      conv_q       <= conv_d;
      wr_q         <= wr_d;
      done_q       <= done_d;
      ovf_q        <= ovf_d;
      busy_q       <= busy_d;
    end
  end

  assign adc_conv_start = conv_q;
  assign fifo_wrreq     = wr_q;
  assign fifo_data      = data_q;
  assign capture_done   = done_q;
  assign overflow_flag  = ovf_q;
  assign busy           = busy_q;
  assign sample_cnt     = sample_cnt_q;

endmodule

// File: tb/tb_echo_capture_writer.sv
// tb_echo_capture_writer: scenario table plus per-cycle reference model for echo_capture_writer.
// Latency: n/a (testbench).
// Backpressure: fifo_full driven per scenario and randomly between samples.
module tb_echo_capture_writer;

  localparam int H   = 6;
  localparam int N   = 3;
  localparam int DIV = 8;
  localparam int CAP = 40;
  localparam int DT  = 2;
  localparam int LAT = 20;
`ifdef ECHO_CAPTURE_DEADTIME_EN
  localparam int GAP = DT;
`else
  localparam int GAP = 0;
`endif

  logic        clk_50M, rst_n, sys_start_pulse, adc_valid, fifo_full;
  logic [11:0] adc_data;
  logic        adc_conv_start, fifo_wrreq, tx_p, tx_n, busy, capture_done, overflow_flag;
  logic [11:0] fifo_data;
  logic [13:0] sample_cnt;

  echo_capture_writer #(
    .TX_HALF_PERIOD (H), .TX_CYCLES (N), .SAMPLE_DIV (DIV),
    .CAPTURE_SAMPLES (CAP), .DEADTIME (DT)
  ) dut (
    .clk_50M (clk_50M), .rst_n (rst_n), .sys_start_pulse (sys_start_pulse),
    .adc_conv_start (adc_conv_start), .adc_valid (adc_valid), .adc_data (adc_data),
    .fifo_wrreq (fifo_wrreq), .fifo_data (fifo_data), .fifo_full (fifo_full),
    .tx_p (tx_p), .tx_n (tx_n), .busy (busy), .capture_done (capture_done),
    .overflow_flag (overflow_flag), .sample_cnt (sample_cnt)
  );

  initial begin
    clk_50M = 1'b0;
    forever #10 clk_50M = ~clk_50M;
  end

  typedef struct {
    int full_lo;
    int full_hi;
    int restart_at;
    bit rand_full;
    int exp_writes;
    int exp_ovf;
    int exp_tx_edges;
  } scen_t;

  scen_t tbl[6];
  scen_t cur;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state.
  bit   m_active;
  int   m_start, m_cnt, run_no;
  bit   m_ovf;
  bit   e_tx_p, e_tx_n, e_conv, e_wr, e_done, e_busy, e_ovf;
  int   e_cnt;
  logic [11:0] e_data;
  int   ret_q[$];
  int   wr_seen, done_seen, txp_rise, txn_rise;
  bit   prev_tx_p, prev_tx_n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit valid_due();
    return (ret_q.size() > 0) && (ret_q[0] == cyc);
  endfunction

  task automatic observe();
    chk("tx_p", tx_p, e_tx_p);
    chk("tx_n", tx_n, e_tx_n);
    chk("adc_conv_start", adc_conv_start, e_conv);
    chk("fifo_wrreq", fifo_wrreq, e_wr);
    if (e_wr) chk("fifo_data", fifo_data, e_data);
    chk("capture_done", capture_done, e_done);
    chk("busy", busy, e_busy);
    chk("overflow_flag", overflow_flag, e_ovf);
    chk("sample_cnt", sample_cnt, e_cnt);
    if (fifo_wrreq === 1'b1) wr_seen++;
    if (capture_done === 1'b1) done_seen++;
    if (tx_p === 1'b1 && !prev_tx_p) txp_rise++;
    if (tx_n === 1'b1 && !prev_tx_n) txn_rise++;
    prev_tx_p = (tx_p === 1'b1);
    prev_tx_n = (tx_n === 1'b1);
    // ADC behaviour: each request returns a sample LAT cycles later.
    if (adc_conv_start === 1'b1) ret_q.push_back(cyc + LAT);
  endtask

  task automatic tick(input bit start, input bit inject);
    bit v, f;
    logic [11:0] d;
    int k, junk;
    observe();
    v = inject;
    while (ret_q.size() > 0 && ret_q[0] <= cyc) begin
      if (ret_q[0] == cyc) v = 1'b1;
      junk = ret_q.pop_front();
    end
    d = 12'($urandom);
    if (v) f = (run_no == 0 && m_cnt >= cur.full_lo && m_cnt <= cur.full_hi) ||
               (cur.rand_full && $urandom_range(0, 3) == 0);
    else   f = 1'($urandom_range(0, 1));
    // Expected outputs for the next cycle, from the measurement rules.
    e_wr = 1'b0;
    e_done = 1'b0;
    if (start) begin
      m_active = 1'b1; m_start = cyc; m_cnt = 0; m_ovf = 1'b0;
    end else if (v && m_active) begin
      m_cnt++;
      if (f) m_ovf = 1'b1;
      else begin e_wr = 1'b1; e_data = d; end
      if (m_cnt == CAP) begin m_active = 1'b0; e_done = 1'b1; end
    end
    k = cyc - m_start;
    e_busy = m_active;
    e_cnt  = m_cnt;
    e_ovf  = m_ovf;
    e_tx_p = m_active && k < 2*N*H && (k % (2*H)) <  H && (k % H) >= GAP;
    e_tx_n = m_active && k < 2*N*H && (k % (2*H)) >= H && (k % H) >= GAP;
    e_conv = m_active && (k % DIV) == 0 && (k / DIV) < CAP;
    sys_start_pulse = start;
    adc_valid = v;
    adc_data  = d;
    fifo_full = f;
    @(posedge clk_50M);
    #1;
    cyc++;
  endtask

  task automatic clear_model();
    m_active = 1'b0; m_cnt = 0; m_ovf = 1'b0;
    e_tx_p = 0; e_tx_n = 0; e_conv = 0; e_wr = 0; e_done = 0; e_busy = 0; e_ovf = 0; e_cnt = 0;
  endtask

  task automatic reset_mid();
    int junk;
    observe();
    #2;
    rst_n = 1'b0; sys_start_pulse = 1'b0; adc_valid = 1'b0; fifo_full = 1'b0;
    #1;
    chk("rst_tx_p", tx_p, 0);
    chk("rst_tx_n", tx_n, 0);
    chk("rst_busy", busy, 0);
    chk("rst_conv", adc_conv_start, 0);
    chk("rst_wrreq", fifo_wrreq, 0);
    chk("rst_fifo_data", fifo_data, 0);
    chk("rst_sample_cnt", sample_cnt, 0);
    chk("rst_overflow", overflow_flag, 0);
    chk("rst_done", capture_done, 0);
    clear_model();
    while (ret_q.size() > 0 && ret_q[0] <= cyc) junk = ret_q.pop_front();
    @(negedge clk_50M);
    rst_n = 1'b1;
    @(posedge clk_50M);
    #1;
    cyc++;
  endtask

  task automatic run_scenario(input int s);
    cur = tbl[s];
    run_no = 0; wr_seen = 0; done_seen = 0; txp_rise = 0; txn_rise = 0;
    while (valid_due()) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    for (int t = 0; t < 4000; t++) begin
      if (done_seen > 0 && ret_q.size() == 0) break;
      if (run_no == 0 && cur.restart_at >= 0 && m_cnt == cur.restart_at && !valid_due()) begin
        run_no = 1;
        tick(1'b1, 1'b0);
      end else begin
        tick(1'b0, 1'b0);
      end
    end
    // Stray strobes while in DONE must be ignored.
    for (int i = 0; i < 6; i++) tick(1'b0, (i == 1) || (i == 4));
    chk("done_pulses", done_seen, 1);
    chk("final_sample_cnt", sample_cnt, CAP);
    chk("final_busy", busy, 0);
    if (cur.exp_writes >= 0) chk("fifo_writes", wr_seen, cur.exp_writes);
    if (cur.exp_ovf >= 0)    chk("final_overflow", overflow_flag, cur.exp_ovf);
    chk("tx_p_pulses", txp_rise, cur.exp_tx_edges);
    chk("tx_n_pulses", txn_rise, cur.exp_tx_edges);
  endtask

  initial begin
    //            lo  hi  restart           rand writes ovf edges
    tbl[0] = '{1,  0,  -1,                   0,   40,    0,  N};
    tbl[1] = '{10, 14, -1,                   0,   35,    1,  N};
    tbl[2] = '{1,  0,  15,                   0,   55,    0,  2*N};
    tbl[3] = '{5,  7,  15,                   0,   52,    0,  2*N};
    tbl[4] = '{1,  0,  $urandom_range(5, 30), 1,  -1,   -1,  2*N};
    tbl[5] = '{1,  0,  0,                    0,   40,    0,  N};
    cur = tbl[0];
    run_no = 0;
    m_start = 0;
    prev_tx_p = 0; prev_tx_n = 0;
    clear_model();
    sys_start_pulse = 0; adc_valid = 0; fifo_full = 0; adc_data = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk_50M);
    #1;
    chk("reset_tx_p", tx_p, 0);
    chk("reset_tx_n", tx_n, 0);
    chk("reset_busy", busy, 0);
    chk("reset_conv", adc_conv_start, 0);
    chk("reset_wrreq", fifo_wrreq, 0);
    chk("reset_fifo_data", fifo_data, 0);
    chk("reset_done", capture_done, 0);
    chk("reset_overflow", overflow_flag, 0);
    chk("reset_sample_cnt", sample_cnt, 0);
    @(negedge clk_50M);
    rst_n = 1'b1;
    @(posedge clk_50M);
    #1;
    cyc = 0;

    // Stray strobes while IDLE.
    for (int i = 0; i < 10; i++) tick(1'b0, (i % 3) == 0);

    for (int s = 0; s < 6; s++) run_scenario(s);

    // Asynchronous reset in the middle of the burst, then quiet until a new start.
    cur = tbl[0];
    run_no = 0;
    tick(1'b1, 1'b0);
    repeat (14) tick(1'b0, 1'b0);
    reset_mid();
    repeat (40) tick(1'b0, 1'b0);
    run_scenario(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
